// File: rtl/shift_unit_arbiter.sv
// Two-port arbiter in front of a shared 32-bit shifter (SRL/SLL/SRA/pass)
// with a single-entry result register and valid/ready flow on both sides.
module shift_unit_arbiter #(
  parameter bit          RR_EN      = 1'b1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_shamt,
  input  logic [1:0]  req0_type,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_shamt,
  input  logic [1:0]  req1_type,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_r,
  output logic        busy
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] resp_r_q, resp_r_d;
  logic        resp_id_q, resp_id_d;

  logic        can_accept;
  logic        both_valid;
  logic        grant0, grant1;
  logic        xfer0, xfer1, xfer;
  logic [31:0] sel_a;
  logic [4:0]  sel_shamt;
  logic [1:0]  sel_type;
  logic [31:0] shift_res;

  function automatic logic [31:0] do_shift(input logic [31:0] a,
                                           input logic [4:0]  sh,
                                           input logic [1:0]  op);
    logic [31:0] r;
    case (op)
      2'b00:   r = a >> sh;
      2'b01:   r = a << sh;
      2'b10:   r = 32'($signed(a) >>> sh);
      default: r = a;
    endcase
    return r;
  endfunction

  assign can_accept = (state_q == StEmpty) || resp_ready;
  assign both_valid = req0_valid && req1_valid;

  // Grant is decided regardless of can_accept; ready gates the actual transfer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (both_valid) begin
      if (RR_EN) begin
        grant1 = prio_q;
      end else begin
        grant1 = (starve_q == StarveMax);
      end
      grant0 = !grant1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = can_accept && grant0;
  assign req1_ready = can_accept && grant1;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign xfer       = xfer0 || xfer1;

  always_comb begin
    sel_a     = req0_a;
    sel_shamt = req0_shamt;
    sel_type  = req0_type;
    if (grant1) begin
      sel_a     = req1_a;
      sel_shamt = req1_shamt;
      sel_type  = req1_type;
    end
  end

  assign shift_res = do_shift(sel_a, sel_shamt, sel_type);

  always_comb begin
    state_d   = state_q;
    resp_r_d  = resp_r_q;
    resp_id_d = resp_id_q;
    prio_d    = prio_q;
    starve_d  = starve_q;

    if (xfer) begin
      state_d = StFull;
    end else if (state_q == StFull && resp_ready) begin
      state_d = StEmpty;
    end

    if (xfer) begin
      resp_r_d  = shift_res;
      resp_id_d = xfer1;
      prio_d    = !xfer1;
    end

    if (can_accept) begin
      if (xfer1 || !req1_valid) begin
        starve_d = 4'd0;
      end else if (both_valid && xfer0 && starve_q != 4'hF) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StEmpty;
      prio_q    <= 1'b0;
      starve_q  <= 4'd0;
      resp_r_q  <= 32'd0;
      resp_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      starve_q  <= starve_d;
      resp_r_q  <= resp_r_d;
      resp_id_q <= resp_id_d;
    end
  end

  assign resp_valid = (state_q == StFull);
  assign busy       = resp_valid;
  assign resp_r     = resp_r_q;
  assign resp_id    = resp_id_q;

`ifndef SYNTHESIS
  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_r) && $stable(resp_id)));
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: one round-robin instance and one
// fixed-priority instance (STARVE_MAX=4) driven by the same stimulus.
module tb_shift_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req1_a;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_type, req1_type;
  logic        resp_ready;

  logic        rr_req0_ready, rr_req1_ready, rr_resp_valid, rr_resp_id, rr_busy;
  logic [31:0] rr_resp_r;
  logic        fp_req0_ready, fp_req1_ready, fp_resp_valid, fp_resp_id, fp_busy;
  logic [31:0] fp_resp_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_unit_arbiter #(.RR_EN(1'b1), .STARVE_MAX(4)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_type(req0_type),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_type(req1_type),
    .resp_valid(rr_resp_valid), .resp_ready(resp_ready), .resp_id(rr_resp_id),
    .resp_r(rr_resp_r), .busy(rr_busy)
  );

  shift_unit_arbiter #(.RR_EN(1'b0), .STARVE_MAX(4)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_type(req0_type),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_type(req1_type),
    .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id),
    .resp_r(fp_resp_r), .busy(fp_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_a = 0; req0_shamt = 0; req0_type = 0;
    req1_valid = 0; req1_a = 0; req1_shamt = 0; req1_type = 0;
    resp_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rr_resp_valid, rr_busy, rr_resp_id, rr_resp_r} !== 35'd0) begin
      failures++;
      $display("FAIL reset_rr got v=%b b=%b id=%b r=%h want all zero",
               rr_resp_valid, rr_busy, rr_resp_id, rr_resp_r);
    end
    checks++;
    if ({fp_resp_valid, fp_busy, fp_resp_id, fp_resp_r} !== 35'd0) begin
      failures++;
      $display("FAIL reset_fp got v=%b b=%b id=%b r=%h want all zero",
               fp_resp_valid, fp_busy, fp_resp_id, fp_resp_r);
    end
  endtask

  task automatic test_srl_port0();
    do_reset();
    req0_valid = 1; req0_a = 32'h8000_0000; req0_shamt = 5'd4; req0_type = 2'b00;
    #1;
    checks++;
    if ({rr_req0_ready, rr_req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL srl_ready got %b%b want 10", rr_req0_ready, rr_req1_ready);
    end
    tick();
    req0_valid = 0;
    checks++;
    if ({rr_resp_valid, rr_busy, rr_resp_id, rr_resp_r} !== {1'b1, 1'b1, 1'b0, 32'h0800_0000}) begin
      failures++;
      $display("FAIL srl_resp got v=%b b=%b id=%b r=%h want 1 1 0 08000000",
               rr_resp_valid, rr_busy, rr_resp_id, rr_resp_r);
    end
    tick();
    checks++;
    if (rr_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL srl_drain got v=%b want 0", rr_resp_valid);
    end
  endtask

  task automatic test_port1_ops();
    do_reset();
    req1_valid = 1; req1_a = 32'h8000_0000; req1_shamt = 5'd4; req1_type = 2'b10;
    tick();
    req1_a = 32'h0000_1234; req1_shamt = 5'd7; req1_type = 2'b11;
    checks++;
    if ({rr_resp_valid, rr_resp_id, rr_resp_r} !== {1'b1, 1'b1, 32'hF800_0000}) begin
      failures++;
      $display("FAIL sra_resp got v=%b id=%b r=%h want 1 1 f8000000",
               rr_resp_valid, rr_resp_id, rr_resp_r);
    end
    tick();
    req1_valid = 0;
    checks++;
    if ({rr_resp_valid, rr_resp_id, rr_resp_r} !== {1'b1, 1'b1, 32'h0000_1234}) begin
      failures++;
      $display("FAIL pass_resp got v=%b id=%b r=%h want 1 1 00001234",
               rr_resp_valid, rr_resp_id, rr_resp_r);
    end
    tick();
  endtask

  task automatic test_shift_types();
    logic [31:0] va [6];
    logic [4:0]  vs [6];
    logic [1:0]  vt [6];
    logic [31:0] ve [6];
    va[0] = 32'h8000_0001; vs[0] = 5'd0;  vt[0] = 2'b10; ve[0] = 32'h8000_0001;
    va[1] = 32'h0000_0001; vs[1] = 5'd31; vt[1] = 2'b01; ve[1] = 32'h8000_0000;
    va[2] = 32'hFFFF_FFFF; vs[2] = 5'd31; vt[2] = 2'b00; ve[2] = 32'h0000_0001;
    va[3] = 32'h8000_0000; vs[3] = 5'd31; vt[3] = 2'b10; ve[3] = 32'hFFFF_FFFF;
    va[4] = 32'h7FFF_FFFF; vs[4] = 5'd31; vt[4] = 2'b10; ve[4] = 32'h0000_0000;
    va[5] = 32'hDEAD_BEEF; vs[5] = 5'd0;  vt[5] = 2'b01; ve[5] = 32'hDEAD_BEEF;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1; req0_a = va[i]; req0_shamt = vs[i]; req0_type = vt[i];
      tick();
      checks++;
      if ({rr_resp_valid, rr_resp_id, rr_resp_r} !== {1'b1, 1'b0, ve[i]}) begin
        failures++;
        $display("FAIL shift_vec%0d got v=%b id=%b r=%h want 1 0 %h",
                 i, rr_resp_valid, rr_resp_id, rr_resp_r, ve[i]);
      end
    end
    req0_valid = 0;
    tick();
  endtask

  task automatic test_rr_alternate();
    logic [31:0] exp_r;
    do_reset();
    req0_valid = 1; req0_a = 32'h0000_0001; req0_shamt = 5'd1; req0_type = 2'b01;
    req1_valid = 1; req1_a = 32'h0000_0100; req1_shamt = 5'd4; req1_type = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_r = (i % 2 == 0) ? 32'h0000_0002 : 32'h0000_0010;
      checks++;
      if ({rr_resp_valid, rr_resp_id, rr_resp_r} !== {1'b1, 1'(i % 2), exp_r}) begin
        failures++;
        $display("FAIL rr_seq%0d got v=%b id=%b r=%h want 1 %0d %h",
                 i, rr_resp_valid, rr_resp_id, rr_resp_r, i % 2, exp_r);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starve();
    logic exp_id [6];
    exp_id[0] = 0; exp_id[1] = 0; exp_id[2] = 0; exp_id[3] = 0; exp_id[4] = 1; exp_id[5] = 0;
    do_reset();
    req0_valid = 1; req0_a = 32'h0000_00F0; req0_shamt = 5'd4; req0_type = 2'b00;
    req1_valid = 1; req1_a = 32'h0000_000F; req1_shamt = 5'd4; req1_type = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({fp_resp_valid, fp_resp_id, fp_resp_r} !==
          {1'b1, exp_id[i], exp_id[i] ? 32'h0000_00F0 : 32'h0000_000F}) begin
        failures++;
        $display("FAIL starve_seq%0d got v=%b id=%b r=%h want v=1 id=%b",
                 i, fp_resp_valid, fp_resp_id, fp_resp_r, exp_id[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    req0_valid = 1; req0_a = 32'h0000_00F0; req0_shamt = 5'd4; req0_type = 2'b00;
    tick();
    resp_ready = 0;
    req0_a = 32'h0000_0F00;
    req1_valid = 1; req1_a = 32'h1; req1_shamt = 5'd1; req1_type = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({rr_req0_ready, rr_req1_ready, rr_resp_valid, rr_resp_id, rr_resp_r} !==
          {1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_000F}) begin
        failures++;
        $display("FAIL stall%0d got r0=%b r1=%b v=%b id=%b r=%h want 0 0 1 0 0000000f",
                 i, rr_req0_ready, rr_req1_ready, rr_resp_valid, rr_resp_id, rr_resp_r);
      end
      tick();
    end
    req1_valid = 0;
    resp_ready = 1;
    #1;
    checks++;
    if (rr_req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready got %b want 1", rr_req0_ready);
    end
    tick();
    req0_valid = 0;
    checks++;
    if ({rr_resp_valid, rr_resp_id, rr_resp_r} !== {1'b1, 1'b0, 32'h0000_00F0}) begin
      failures++;
      $display("FAIL stall_reload got v=%b id=%b r=%h want 1 0 000000f0",
               rr_resp_valid, rr_resp_id, rr_resp_r);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    // Leave prio pointing at port 1 so the reset has something to undo.
    req0_valid = 1; req0_a = 32'h55; req0_shamt = 5'd0; req0_type = 2'b11;
    tick();
    req0_valid = 0;
    resp_ready = 0;
    #2;
    rst = 1;
    #1;
    checks++;
    if ({rr_resp_valid, rr_busy, fp_resp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset got rr_v=%b rr_b=%b fp_v=%b want 000",
               rr_resp_valid, rr_busy, fp_resp_valid);
    end
    tick();
    rst = 0;
    resp_ready = 1;
    tick();
    checks++;
    if (rr_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got v=%b want 0", rr_resp_valid);
    end
    req0_valid = 1; req0_a = 32'h0000_0003; req0_shamt = 5'd2; req0_type = 2'b01;
    req1_valid = 1; req1_a = 32'h0000_0040; req1_shamt = 5'd2; req1_type = 2'b00;
    tick();
    idle_inputs();
    checks++;
    if ({rr_resp_valid, rr_resp_id, rr_resp_r} !== {1'b1, 1'b0, 32'h0000_000C}) begin
      failures++;
      $display("FAIL post_reset_grant got v=%b id=%b r=%h want 1 0 0000000c",
               rr_resp_valid, rr_resp_id, rr_resp_r);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_srl_port0();
    test_port1_ops();
    test_shift_types();
    test_rr_alternate();
    test_starve();
    test_stall();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
